// File: rtl/wb_pkg.sv
// Shared types and constants for the GPR write-port arbiter.
package wb_pkg;

    typedef enum logic {WBA_NORMAL, WBA_FORCE} wba_state_t;

    typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_MDU, SRC_LD} wb_src_t;

    localparam int unsigned GPR_ZERO = 0;
    localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-requester round-robin picker: req[0]=MDU, req[1]=load; rr=0 favours req[0].
module wb_rr_pick (
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt,
    output logic       rr_next
);

    always_comb begin
        gnt[0] = req[0] & (~req[1] | ~rr);
        gnt[1] = req[1] & (~req[0] |  rr);
        // After a grant, point at the requester that did not win.
        if (gnt[0]) begin
            rr_next = 1'b1;
        end else if (gnt[1]) begin
            rr_next = 1'b0;
        end else begin
            rr_next = rr;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Single GPR write-port scheduler: pipeline priority, MDU/load round-robin,
// starvation counter forcing a side grant with a one-cycle pipeline stall.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic              pipe_stall,
    input  logic              mdu_valid,
    input  logic [ADDR_W-1:0] mdu_waddr,
    input  logic [DATA_W-1:0] mdu_wdata,
    output logic              mdu_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_waddr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic              gpr_we,
    output logic [ADDR_W-1:0] gpr_waddr,
    output logic [DATA_W-1:0] gpr_wdata
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIMIT);

    wba_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic              rr_q, rr_d;
    logic              gpr_we_q;
    logic [ADDR_W-1:0] gpr_waddr_q;
    logic [DATA_W-1:0] gpr_wdata_q;

    wb_src_t           src;
    logic [1:0]        side_gnt;
    logic              rr_next;
    logic              side_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    wb_rr_pick u_rr_pick (
        .req     ({ld_valid, mdu_valid}),
        .rr      (rr_q),
        .gnt     (side_gnt),
        .rr_next (rr_next)
    );

    assign side_any = mdu_valid | ld_valid;
    assign cnt_inc  = (cnt_q >= CNT_LIM) ? CNT_LIM : cnt_q + CNT_W'(1);

    // Next-state, counter, round-robin pointer and ready/stall decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        src        = SRC_NONE;
        pipe_stall = 1'b0;
        mdu_ready  = 1'b0;
        ld_ready   = 1'b0;

        if (!rst) begin
            unique case (state_q)
                WBA_NORMAL: begin
                    if (pipe_valid) begin
                        src = SRC_PIPE;
                        if (side_any) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNT_LIM) begin
                                state_d = WBA_FORCE;
                            end
                        end
                    end else if (side_any) begin
                        src       = side_gnt[0] ? SRC_MDU : SRC_LD;
                        mdu_ready = side_gnt[0];
                        ld_ready  = side_gnt[1];
                        cnt_d     = '0;
                        rr_d      = rr_next;
                    end
                end
                WBA_FORCE: begin
                    pipe_stall = 1'b1;
                    state_d    = WBA_NORMAL;
                    if (side_any) begin
                        src       = side_gnt[0] ? SRC_MDU : SRC_LD;
                        mdu_ready = side_gnt[0];
                        ld_ready  = side_gnt[1];
                        cnt_d     = '0;
                        rr_d      = rr_next;
                    end
                end
                default: state_d = WBA_NORMAL;
            endcase
        end
    end

    // Write-data mux for the granted source.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        unique case (src)
            SRC_PIPE: begin sel_addr = pipe_waddr; sel_data = pipe_wdata; end
            SRC_MDU:  begin sel_addr = mdu_waddr;  sel_data = mdu_wdata;  end
            SRC_LD:   begin sel_addr = ld_waddr;   sel_data = ld_wdata;   end
            default:  begin sel_addr = '0;         sel_data = '0;         end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= WBA_NORMAL;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            gpr_we_q    <= 1'b0;
            gpr_waddr_q <= '0;
            gpr_wdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            // Writes to register zero complete the handshake but never reach the file.
            gpr_we_q <= (src != SRC_NONE) && (sel_addr != ADDR_W'(GPR_ZERO));
            if (src != SRC_NONE) begin
                gpr_waddr_q <= sel_addr;
                gpr_wdata_q <= sel_data;
            end
        end
    end

    assign gpr_we    = gpr_we_q;
    assign gpr_waddr = gpr_waddr_q;
    assign gpr_wdata = gpr_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus starvation and reset-mid-FORCE sequences.
module tb_wb_port_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              pipe_valid, mdu_valid, ld_valid;
    logic [ADDR_W-1:0] pipe_waddr, mdu_waddr, ld_waddr;
    logic [DATA_W-1:0] pipe_wdata, mdu_wdata, ld_wdata;
    logic              pipe_stall, mdu_ready, ld_ready;
    logic              gpr_we;
    logic [ADDR_W-1:0] gpr_waddr;
    logic [DATA_W-1:0] gpr_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_waddr (pipe_waddr),
        .pipe_wdata (pipe_wdata),
        .pipe_stall (pipe_stall),
        .mdu_valid  (mdu_valid),
        .mdu_waddr  (mdu_waddr),
        .mdu_wdata  (mdu_wdata),
        .mdu_ready  (mdu_ready),
        .ld_valid   (ld_valid),
        .ld_waddr   (ld_waddr),
        .ld_wdata   (ld_wdata),
        .ld_ready   (ld_ready),
        .gpr_we     (gpr_we),
        .gpr_waddr  (gpr_waddr),
        .gpr_wdata  (gpr_wdata)
    );

    typedef struct {
        string             name;
        logic              rst;
        logic              pv;
        logic [ADDR_W-1:0] pa;
        logic [DATA_W-1:0] pd;
        logic              mv;
        logic [ADDR_W-1:0] ma;
        logic [DATA_W-1:0] md;
        logic              lv;
        logic [ADDR_W-1:0] la;
        logic [DATA_W-1:0] ld;
        logic [2:0]        hs;     // {pipe_stall, mdu_ready, ld_ready} in this cycle
        logic              we;     // gpr_we after the edge
        logic              chkd;   // also check gpr_waddr/gpr_wdata after the edge
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } vec_t;

    vec_t vecs[$];

    // One cycle: drive just after posedge, check handshake mid-cycle, check write port after the next edge.
    task automatic run_cycle(input vec_t v);
        logic [2:0] hs_act;
        rst        = v.rst;
        pipe_valid = v.pv; pipe_waddr = v.pa; pipe_wdata = v.pd;
        mdu_valid  = v.mv; mdu_waddr  = v.ma; mdu_wdata  = v.md;
        ld_valid   = v.lv; ld_waddr   = v.la; ld_wdata   = v.ld;
        #3;
        hs_act = {pipe_stall, mdu_ready, ld_ready};
        checks++;
        if (hs_act !== v.hs) begin
            errors++;
            $display("FAIL %s handshake {stall,mdu_rdy,ld_rdy}: got %b expected %b", v.name, hs_act, v.hs);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gpr_we !== v.we ||
            (v.chkd && (gpr_waddr !== v.wa || gpr_wdata !== v.wd))) begin
            errors++;
            $display("FAIL %s write port: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                     v.name, gpr_we, gpr_waddr, gpr_wdata, v.we, v.wa, v.wd);
        end
    endtask

    function automatic vec_t mk(input string name, input logic r,
                                input logic pv, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd,
                                input logic mv, input logic [ADDR_W-1:0] ma, input logic [DATA_W-1:0] md,
                                input logic lv, input logic [ADDR_W-1:0] la, input logic [DATA_W-1:0] ld,
                                input logic [2:0] hs, input logic we, input logic chkd,
                                input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        vec_t v;
        v.name = name; v.rst = r;
        v.pv = pv; v.pa = pa; v.pd = pd;
        v.mv = mv; v.ma = ma; v.md = md;
        v.lv = lv; v.la = la; v.ld = ld;
        v.hs = hs; v.we = we; v.chkd = chkd; v.wa = wa; v.wd = wd;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        pipe_valid = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
        mdu_valid  = 1'b0; mdu_waddr  = '0; mdu_wdata  = '0;
        ld_valid   = 1'b0; ld_waddr   = '0; ld_wdata   = '0;

        // Table: each row is one clock cycle.
        vecs.push_back(mk("rst_all_valid_0", 1, 1,1,32'h1, 1,2,32'h2, 1,4,32'h4, 3'b000, 0,1,0,32'h0));
        vecs.push_back(mk("rst_all_valid_1", 1, 1,1,32'h1, 1,2,32'h2, 1,4,32'h4, 3'b000, 0,1,0,32'h0));
        vecs.push_back(mk("release_pipe_first", 0, 1,1,32'h1, 1,2,32'h2, 1,4,32'h4, 3'b000, 1,1,1,32'h1));
        vecs.push_back(mk("rst_idle", 1, 0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 3'b000, 0,1,0,32'h0));
        vecs.push_back(mk("pipe_alone", 0, 1,7,32'hDEADBEEF, 0,0,32'h0, 0,0,32'h0, 3'b000, 1,1,7,32'hDEADBEEF));
        vecs.push_back(mk("reg_zero_load", 0, 0,0,32'h0, 0,0,32'h0, 1,0,32'h55, 3'b001, 0,0,0,32'h0));
        vecs.push_back(mk("rr_mdu_first", 0, 0,0,32'h0, 1,9,32'h99, 1,10,32'hAA, 3'b010, 1,1,9,32'h99));
        vecs.push_back(mk("rr_load_second", 0, 0,0,32'h0, 1,9,32'h99, 1,10,32'hAA, 3'b001, 1,1,10,32'hAA));
        vecs.push_back(mk("idle_no_write", 0, 0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 3'b000, 0,1,10,32'hAA));
        vecs.push_back(mk("mdu_alone", 0, 0,0,32'h0, 1,17,32'h1234, 0,0,32'h0, 3'b010, 1,1,17,32'h1234));

        @(posedge clk);
        #1;
        foreach (vecs[i]) run_cycle(vecs[i]);

        // Starvation: pipe+MDU+load all valid from cnt=0, rr=0.
        run_cycle(mk("starve_rst", 1, 0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 3'b000, 0,1,0,32'h0));
        for (int c = 1; c <= 4; c++)
            run_cycle(mk($sformatf("starve_pipe_%0d", c), 0, 1,5,DATA_W'(c), 1,3,32'h12, 1,6,32'h66,
                         3'b000, 1,1,5,DATA_W'(c)));
        run_cycle(mk("starve_force_mdu", 0, 1,5,32'h5, 1,3,32'h12, 1,6,32'h66, 3'b110, 1,1,3,32'h12));
        // MDU done; the load waits another full starvation window.
        for (int c = 6; c <= 9; c++)
            run_cycle(mk($sformatf("starve_ld_wait_%0d", c), 0, 1,5,DATA_W'(c), 0,0,32'h0, 1,6,32'h66,
                         3'b000, 1,1,5,DATA_W'(c)));
        run_cycle(mk("starve_force_ld", 0, 1,5,32'hA, 0,0,32'h0, 1,6,32'h66, 3'b101, 1,1,6,32'h66));
        run_cycle(mk("starve_after", 0, 1,5,32'hB, 0,0,32'h0, 0,0,32'h0, 3'b000, 1,1,5,32'hB));

        // Reset asserted on the FORCE cycle.
        for (int c = 1; c <= 4; c++)
            run_cycle(mk($sformatf("mf_pipe_%0d", c), 0, 1,8,DATA_W'(c), 1,3,32'h12, 0,0,32'h0,
                         3'b000, 1,1,8,DATA_W'(c)));
        run_cycle(mk("mf_reset_on_force", 1, 1,8,32'h5, 1,3,32'h12, 0,0,32'h0, 3'b000, 0,1,0,32'h0));
        // cnt restarted from 0: four unstalled pipe writes before the next FORCE.
        for (int c = 1; c <= 4; c++)
            run_cycle(mk($sformatf("mf_after_%0d", c), 0, 1,8,DATA_W'(c+16), 1,3,32'h12, 0,0,32'h0,
                         3'b000, 1,1,8,DATA_W'(c+16)));
        run_cycle(mk("mf_force_again", 0, 1,8,32'h15, 1,3,32'h12, 0,0,32'h0, 3'b110, 1,1,3,32'h12));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
